muxn_rr_reg: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer. Successor to the 8:1 combinational single-bit mux.
- Selects one input channel, either directly by a select input or by round-robin arbitration among the valid channels.
- Transfers the selected word through a one-entry output register with a valid/ready handshake on both sides.
- Sits between multiple producer channels and a single downstream consumer.

---
 rtl/muxn_rr_reg_if.sv | 28 ++
 rtl/muxn_rr_reg.sv | 98 +++++++++
 tb/tb_muxn_rr_reg.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/muxn_rr_reg_if.sv
// muxn_rr_reg_if: channel-side and consumer-side handshake bundle
// for the N-channel registered round-robin multiplexer.
interface muxn_rr_reg_if #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
);
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] out_ch;
    logic             sel_err;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch, sel_err
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch, sel_err
    );
endinterface

// File: rtl/muxn_rr_reg.sv
// muxn_rr_reg: N-channel W-bit multiplexer, direct or round-robin
// select, one-entry output register with valid/ready on both sides.
module muxn_rr_reg #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input logic         clk,
    input logic         rst,
    muxn_rr_reg_if.slave bus
);
    logic [W-1:0]     out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [N-1:0]     grant;
    logic [SEL_W-1:0] gidx;
    logic             gany;
    logic             sel_ok;
    logic             load_en;
    logic             xfer;

    // Register may refill in the same cycle it is drained.
    assign load_en = !out_valid_q || bus.out_ready;
    assign sel_ok  = int'(bus.sel) < N;
    assign xfer    = !rst && gany && load_en;

    // Grant: direct index, or first valid channel at/after ptr.
    always_comb begin : grant_p
        int k;
        k     = 0;
        grant = '0;
        gidx  = '0;
        gany  = 1'b0;
        if (!bus.mode) begin
            if (sel_ok && bus.in_valid[bus.sel]) begin
                gany = 1'b1;
                gidx = bus.sel;
            end
        end else begin
            // Descending so the nearest channel to ptr wins last.
            for (int i = N - 1; i >= 0; i--) begin
                k = int'(ptr_q) + i;
                if (k >= N) k = k - N;
                if (bus.in_valid[k]) begin
                    gany = 1'b1;
                    gidx = SEL_W'(k);
                end
            end
        end
        if (gany) grant[gidx] = 1'b1;
    end

    assign bus.in_ready = rst ? '0 : (grant & {N{load_en}});

    // Next state of the output register and round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        sel_err_d   = !bus.mode && !sel_ok;
        if (xfer) begin
            out_data_d  = bus.in_data[int'(gidx)*W +: W];
            out_ch_d    = gidx;
            out_valid_d = 1'b1;
            if (bus.mode) begin
                ptr_d = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State update; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_muxn_rr_reg.sv
// tb_muxn_rr_reg: directed and random checks of muxn_rr_reg
// against a cycle-level behavioural model.
module tb_muxn_rr_reg;
    logic clk;
    logic rst;
    logic rst6;
    int   checks;
    int   errors;

    muxn_rr_reg_if #(.N(8), .W(8)) b8 ();
    muxn_rr_reg_if #(.N(6), .W(8)) b6 ();

    muxn_rr_reg #(.N(8), .W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    muxn_rr_reg #(.N(6), .W(8)) dut6 (
        .clk (clk),
        .rst (rst6),
        .bus (b6.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state for the N=8 instance.
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;
    logic       m_err;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_grant();
        int s;
        s = int'(b8.sel);
        if (!b8.mode) begin
            if (s < 8 && b8.in_valid[s]) return s;
            return -1;
        end
        for (int d = 0; d < 8; d++) begin
            if (b8.in_valid[(m_ptr + d) % 8]) return (m_ptr + d) % 8;
        end
        return -1;
    endfunction

    task automatic step8();
        int         g;
        logic [7:0] er;
        #1;
        g  = ref_grant();
        er = '0;
        if (!rst && g >= 0 && (!m_valid || b8.out_ready)) er[g] = 1'b1;
        chk("in_ready", b8.in_ready, er);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_err = 0;
        end else begin
            m_err = !b8.mode && (int'(b8.sel) >= 8);
            if (er != 0) begin
                m_data  = b8.in_data[g*8 +: 8];
                m_ch    = g;
                m_valid = 1'b1;
                if (b8.mode) m_ptr = (g + 1) % 8;
            end else if (b8.out_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("out_valid", b8.out_valid, m_valid);
        chk("out_data", b8.out_data, m_data);
        chk("out_ch", b8.out_ch, m_ch);
        chk("sel_err", b8.sel_err, m_err);
    endtask

    task automatic set_ch(input int k, input logic [7:0] v);
        b8.in_data[k*8 +: 8] = v;
    endtask

    int exp_seq [6] = '{0, 2, 7, 0, 2, 7};

    initial begin
        checks = 0;
        errors = 0;
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_err = 0;
        rst6 = 1'b1;
        b6.in_data = '0; b6.in_valid = '0; b6.mode = 1'b0;
        b6.sel = '0; b6.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) set_ch(k, 8'(8'h10 * k + k));
        b8.out_ready = 1'b1;
        b8.sel = '0;

        // Reset with every channel requesting.
        rst = 1'b1; b8.mode = 1'b1; b8.in_valid = 8'hFF;
        repeat (2) step8();
        chk("rst_in_ready", b8.in_ready, 0);
        chk("rst_out_valid", b8.out_valid, 0);
        chk("rst_out_data", b8.out_data, 0);
        rst = 1'b0;
        step8();
        chk("rr_first_ch", b8.out_ch, 0);

        // Direct select, sustained throughput.
        b8.mode = 1'b0; b8.sel = 3'd5; b8.in_valid = 8'h20;
        set_ch(5, 8'hA5);
        for (int i = 0; i < 10; i++) begin
            step8();
            chk("dir_ch", b8.out_ch, 5);
            chk("dir_data", b8.out_data, 8'hA5);
        end

        // Backpressure holds the word; refill on drain.
        b8.sel = 3'd3; b8.in_valid = 8'h08; set_ch(3, 8'h11);
        step8();
        b8.out_ready = 1'b0; b8.sel = 3'd2; b8.in_valid = 8'h04;
        set_ch(2, 8'h22);
        for (int i = 0; i < 3; i++) begin
            step8();
            chk("bp_hold", b8.out_data, 8'h11);
            chk("bp_ready", b8.in_ready, 0);
        end
        b8.out_ready = 1'b1;
        step8();
        chk("bp_refill", b8.out_data, 8'h22);
        chk("bp_valid", b8.out_valid, 1);

        // Round-robin fairness and pointer wrap.
        rst = 1'b1; step8(); rst = 1'b0;
        b8.mode = 1'b1; b8.in_valid = 8'h85;
        for (int i = 0; i < 6; i++) begin
            step8();
            chk("rr_seq", b8.out_ch, exp_seq[i]);
        end

        // Mid-operation reset discards the held word.
        b8.out_ready = 1'b0;
        step8();
        rst = 1'b1; step8(); rst = 1'b0;
        chk("mid_rst_valid", b8.out_valid, 0);
        b8.out_ready = 1'b1;

        // Direct transfers leave the round-robin pointer alone.
        b8.in_valid = 8'h08; step8();
        b8.mode = 1'b0; b8.sel = 3'd1; b8.in_valid = 8'h02;
        repeat (2) step8();
        b8.mode = 1'b1; b8.in_valid = 8'hFF;
        step8();
        chk("rr_resume_ch", b8.out_ch, 4);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 40) == 0);
            b8.in_valid  = 8'($urandom);
            b8.in_data   = 64'({$urandom, $urandom});
            b8.mode      = 1'($urandom);
            b8.sel       = 3'($urandom);
            b8.out_ready = ($urandom_range(0, 3) != 0);
            step8();
        end
        rst = 1'b0;

        // Out-of-range select on the N=6 instance.
        @(posedge clk); #1;
        rst6 = 1'b0;
        b6.in_valid = 6'h3F; b6.sel = 3'd7;
        b6.in_data[3*8 +: 8] = 8'h33;
        #1;
        chk("n6_bad_ready", b6.in_ready, 0);
        @(posedge clk); #1;
        chk("n6_sel_err", b6.sel_err, 1);
        chk("n6_bad_valid", b6.out_valid, 0);
        b6.sel = 3'd3;
        #1;
        chk("n6_ok_ready", b6.in_ready, 6'b001000);
        @(posedge clk); #1;
        chk("n6_err_clr", b6.sel_err, 0);
        chk("n6_ch", b6.out_ch, 3);
        chk("n6_data", b6.out_data, 8'h33);
        chk("n6_valid", b6.out_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
